// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - op codes, FSM encoding and sizing constants for the mult/div sequencer
package alu_md_pkg;

  localparam int MD_DATA_WIDTH = 32;
  localparam int ITER_W        = $clog2(MD_DATA_WIDTH);

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_iter_step.sv
// rtl/md_iter_step.sv - one combinational shift/add (mult) or shift/subtract (div) step
module md_iter_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] shadow,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] acc_next,
  output logic [DATA_WIDTH-1:0] shadow_next
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;

  // Mult: acc is the running high half, shadow the multiplier shifting out low.
  // Div: acc is the partial remainder, shadow shifts dividend bits out and quotient bits in.
  always_comb begin
    sum         = {1'b0, acc} + {1'b0, operand};
    shifted     = {acc, shadow[DATA_WIDTH-1]};
    // The remainder after a successful trial is below the divisor, so DW bits suffice.
    diff        = shifted[DATA_WIDTH-1:0] - operand;
    acc_next    = acc;
    shadow_next = shadow;
    if (is_div) begin
      if (shifted >= {1'b0, operand}) begin
        acc_next    = diff;
        shadow_next = {shadow[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_next    = shifted[DATA_WIDTH-1:0];
        shadow_next = {shadow[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      if (shadow[0]) begin
        acc_next    = sum[DATA_WIDTH:1];
        shadow_next = {sum[0], shadow[DATA_WIDTH-1:1]};
      end else begin
        acc_next    = {1'b0, acc[DATA_WIDTH-1:1]};
        shadow_next = {acc[0], shadow[DATA_WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_md_sequencer.sv
// rtl/alu_md_sequencer.sv - iterative mult/multu/div/divu sequencer with start/busy/done handshake
module alu_md_sequencer
  import alu_md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  md_state_e               state;
  logic [CNT_W-1:0]        cnt;
  logic                    is_div;
  logic                    sign_a;
  logic                    sign_b;
  logic                    b_zero;
  logic [DATA_WIDTH-1:0]   a_raw;
  logic [DATA_WIDTH-1:0]   operand;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   shadow;
  logic [DATA_WIDTH-1:0]   acc_next;
  logic [DATA_WIDTH-1:0]   shadow_next;

  logic                    op_div;
  logic                    op_signed;
  logic                    a_neg;
  logic                    b_neg;
  logic [DATA_WIDTH-1:0]   a_mag;
  logic [DATA_WIDTH-1:0]   b_mag;

  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   fix_hi;
  logic [DATA_WIDTH-1:0]   fix_lo;
  logic                    fix_dbz;

  md_iter_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .is_div      (is_div),
    .acc         (acc),
    .shadow      (shadow),
    .operand     (operand),
    .acc_next    (acc_next),
    .shadow_next (shadow_next)
  );

  // Decode the request and reduce signed operands to magnitudes; INT_MIN maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    op_div    = (op == MD_DIVU) || (op == MD_DIV);
    op_signed = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = op_signed & a_in[DATA_WIDTH-1];
    b_neg     = op_signed & b_in[DATA_WIDTH-1];
    a_mag     = a_neg ? -a_in : a_in;
    b_mag     = b_neg ? -b_in : b_in;
  end

  // Re-apply result signs; divide-by-zero bypasses the datapath result entirely.
  always_comb begin
    prod     = {acc, shadow};
    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    fix_hi   = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    fix_lo   = prod_fix[DATA_WIDTH-1:0];
    fix_dbz  = 1'b0;
    if (is_div) begin
      if (b_zero) begin
        fix_hi  = a_raw;
        fix_lo  = '1;
        fix_dbz = 1'b1;
      end else begin
        fix_lo = (sign_a ^ sign_b) ? -shadow : shadow;
        fix_hi = sign_a ? -acc : acc;
      end
    end
  end

  // Sequencer FSM: IDLE latches the request, CALC iterates DW steps, FIXUP publishes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_raw       <= '0;
      operand     <= '0;
      acc         <= '0;
      shadow      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_div      <= op_div;
            sign_a      <= a_neg;
            sign_b      <= b_neg;
            b_zero      <= op_div && (b_in == '0);
            a_raw       <= a_in;
            operand     <= op_div ? b_mag : a_mag;
            shadow      <= op_div ? a_mag : b_mag;
            acc         <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc    <= acc_next;
            shadow <= shadow_next;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              state <= ST_FIXUP;
            end
          end
        end
        ST_FIXUP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (!abort) begin
            hi_out      <= fix_hi;
            lo_out      <= fix_lo;
            div_by_zero <= fix_dbz;
            done        <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_sequencer.sv
// tb/tb_alu_md_sequencer.sv - scoreboard bench for alu_md_sequencer
module tb_alu_md_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  alu_md_sequencer #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      x;
    longint      y;
    e.dbz = 1'b0;
    e.cyc = 0;
    x = o[0] ? longint'($signed(a)) : longint'({32'h0, a});
    y = o[0] ? longint'($signed(b)) : longint'({32'h0, b});
    if (!o[1]) begin
      p    = 64'(x * y);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      p    = 64'(x / y);
      e.lo = p[31:0];
      p    = 64'(x % y);
      e.hi = p[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, including its timing.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi_out", 64'(hi_out), 64'(e.hi));
        check("lo_out", 64'(lo_out), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called on a negedge; start is sampled by the following posedge, done is visible 34 negedges later.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      e.cyc = cyc + 34;
      sb_q.push_back(e);
      last_hi = ehi;
      last_lo = elo;
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic issue_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(o, a, b);
    issue(o, a, b, e.hi, e.lo, e.dbz, 1'b1);
  endtask

  // Returns on the negedge where done is high, so a following issue is back-to-back.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op    = 2'b00;
    a_in  = 32'h0;
    b_in  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_dbz", 64'(div_by_zero), 64'h0);
    check("rst_hi", 64'(hi_out), 64'h0);
    check("rst_lo", 64'(lo_out), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results, issued back to back.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    wait_done();
    issue(2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done();
    issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done();
    issue(2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b1);
    wait_done();
    issue(2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_done();
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
    wait_done();

    // Start while busy is ignored; the accepted op still completes on schedule.
    issue(2'b00, 32'd5, 32'd6, 32'h0, 32'd30, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check("busy_mid_calc", 64'(busy), 64'h1);
    start = 1'b1;
    op    = 2'b10;
    a_in  = 32'd100;
    b_in  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("busy_at_done", 64'(busy), 64'h0);
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1);
    wait_done();

    // Abort in CALC: busy drops, no done, results hold.
    @(negedge clk);
    issue(2'b00, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_hi_hold", 64'(hi_out), 64'(last_hi));
    check("abort_lo_hold", 64'(lo_out), 64'(last_lo));
    repeat (40) @(negedge clk);
    check("abort_busy_stays", 64'(busy), 64'h0);

    // Abort and start together in IDLE: start wins.
    abort = 1'b1;
    issue_model(2'b11, 32'd1000, 32'hFFFF_FFFD);
    abort = 1'b0;
    wait_done();

    // Randomized ops with occasional zero divisors, INT_MIN operands and gaps.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 300));
        3: b = -32'($urandom_range(1, 300));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue_model(o, a, b);
      wait_done();
    end

    // Reset mid-CALC clears everything immediately.
    @(negedge clk);
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_done", 64'(done), 64'h0);
    check("midrst_dbz", 64'(div_by_zero), 64'h0);
    check("midrst_hi", 64'(hi_out), 64'h0);
    check("midrst_lo", 64'(lo_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_model(2'b10, 32'hDEAD_BEEF, 32'h0000_0101);
    wait_done();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
